// File: rtl/fetch_dec_queue.sv
// ---------------------------------------------------------------------------
// fetch_dec_queue
//
// Instruction queue sitting between the fetch and decode stages. It holds up
// to DEPTH fetched entries so that fetch can keep running while decode is
// stalled. Both sides use a valid/ready handshake. A kill flushes every
// buffered entry in a single cycle.
//
// Each entry carries the instruction, its PC, the predicted next PC, the
// predictor hit/taken flags and the two fetch exception flags. The exception
// flags are presented to decode as an EXC_W-wide vector. Bit 0 is the
// misaligned-fetch flag and bit 12 is the access-fault flag. EXC_W must be
// at least 13.
//
// Ports:
//   clk_i                         clock
//   rsn_i                         asynchronous active-low reset
//   kill_i                        synchronous flush of all entries
//   fetch_valid_i / fetch_ready_o fetch-side handshake
//   fetch_misaligned_instr_exc_i  misaligned-fetch exception flag
//   fetch_instr_fault_exc_i       instruction access-fault flag
//   fetch_instr_i                 instruction word
//   fetch_pc_i                    PC of the instruction
//   fetch_pred_pc_i               predicted next PC
//   fetch_prediction_i            predictor hit
//   fetch_taken_i                 predicted taken
//   dec_valid_o / dec_ready_i     decode-side handshake
//   dec_instr_o, dec_pc_o,
//   dec_pred_pc_o                 head entry fields (zero when empty)
//   dec_prediction_o, dec_taken_o head entry flags (zero when empty)
//   dec_exc_bits_o                head entry exception vector (zero when empty)
//   count_o                       current occupancy
// ---------------------------------------------------------------------------
module fetch_dec_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int EXC_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic                       kill_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic                       fetch_misaligned_instr_exc_i,
    input  logic                       fetch_instr_fault_exc_i,
    input  logic [XLEN-1:0]            fetch_instr_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    input  logic [XLEN-1:0]            fetch_pred_pc_i,
    input  logic                       fetch_prediction_i,
    input  logic                       fetch_taken_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [XLEN-1:0]            dec_pred_pc_o,
    output logic                       dec_prediction_o,
    output logic                       dec_taken_o,
    output logic [EXC_W-1:0]           dec_exc_bits_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 3 * XLEN + 4;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Field positions inside a stored entry.
    localparam int INSTR_LSB   = 0;
    localparam int PC_LSB      = XLEN;
    localparam int PRED_PC_LSB = 2 * XLEN;
    localparam int PRED_BIT    = 3 * XLEN;
    localparam int TAKEN_BIT   = 3 * XLEN + 1;
    localparam int FAULT_BIT   = 3 * XLEN + 2;
    localparam int MISAL_BIT   = 3 * XLEN + 3;

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;

    // Ready and valid come only from the registered count, so there is no
    // combinational path from dec_ready_i to fetch_ready_o. A full queue
    // refuses a push even while it pops in the same cycle.
    assign fetch_ready_o = (count != FULL_COUNT);
    assign dec_valid_o   = (count != '0);
    assign count_o       = count;

    assign push = fetch_valid_i && fetch_ready_o && !kill_i;
    assign pop  = dec_valid_o && dec_ready_i && !kill_i;

    // Only the two exception flags are stored; the full-width vector is
    // rebuilt at the read side since every other bit is always zero.
    assign wr_entry = {fetch_misaligned_instr_exc_i, fetch_instr_fault_exc_i,
                       fetch_taken_i, fetch_prediction_i,
                       fetch_pred_pc_i, fetch_pc_i, fetch_instr_i};

    // Storage is not reset; valid entries are tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // natural pointer rollover gives the modulo-DEPTH wrap.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (kill_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Head entry presented to decode; an empty queue shows an all-zero
    // bubble, which decode already treats as a no-op.
    always_comb begin
        dec_instr_o      = '0;
        dec_pc_o         = '0;
        dec_pred_pc_o    = '0;
        dec_prediction_o = 1'b0;
        dec_taken_o      = 1'b0;
        dec_exc_bits_o   = '0;
        if (dec_valid_o) begin
            dec_instr_o       = head[INSTR_LSB +: XLEN];
            dec_pc_o          = head[PC_LSB +: XLEN];
            dec_pred_pc_o     = head[PRED_PC_LSB +: XLEN];
            dec_prediction_o  = head[PRED_BIT];
            dec_taken_o       = head[TAKEN_BIT];
            dec_exc_bits_o[0]  = head[MISAL_BIT];
            dec_exc_bits_o[12] = head[FAULT_BIT];
        end
    end

endmodule
